// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-memory bridge.
// Imported by the bridge top and its lane aligner.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    DRAIN
  } mem_bridge_state_t;

  localparam int MEM_BRIDGE_TIMEOUT = 255;

  typedef logic [3:0] rv32i_mem_wmask;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment between CPU lane-0 data and word memory.
// Purely combinational; also flags masks that spill past the word.
module mem_lane_align
  import mem_bridge_pkg::*;
(
  input  logic [1:0]     off,
  input  logic [31:0]    wdata,
  input  rv32i_mem_wmask mask,
  input  logic [31:0]    rdata,
  output logic [31:0]    wdata_sh,
  output rv32i_mem_wmask mask_sh,
  output logic           ovf,
  output logic [31:0]    rdata_sh
);

  logic [7:0] mask_wide;
  logic [4:0] bit_sh;

  assign bit_sh    = {off, 3'b000};
  assign mask_wide = {4'b0000, mask} << off;
  assign mask_sh   = mask_wide[3:0];
  assign ovf       = |mask_wide[7:4];
  assign wdata_sh  = wdata << bit_sh;
  assign rdata_sh  = rdata >> bit_sh;

endmodule

// File: rtl/mem_bridge.sv
// Bridge from level-held CPU requests to a req/gnt/rvalid memory port.
// Handles lane alignment, misalignment errors and a response timeout.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = MEM_BRIDGE_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic [31:0]    mem_address,
  input  logic [31:0]    mem_wdata,
  input  rv32i_mem_wmask mem_byte_enable,
  output logic [31:0]    mem_rdata,
  output logic           mem_resp,
  output logic           mem_err,
  output logic           pmem_req,
  output logic           pmem_we,
  output logic [31:0]    pmem_addr,
  output logic [31:0]    pmem_wdata,
  output rv32i_mem_wmask pmem_wmask,
  input  logic           pmem_gnt,
  input  logic           pmem_rvalid,
  input  logic [31:0]    pmem_rdata
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  mem_bridge_state_t state_q, state_d;

  logic [1:0]     off_q;
  logic           we_q;
  logic           pend_q;
  logic [7:0]     cnt_q;
  logic [1:0]     align_off;
  logic [31:0]    wdata_sh;
  logic [31:0]    rdata_sh;
  rv32i_mem_wmask mask_sh;
  logic           ovf;
  logic           accept;
  logic           err_d;
  logic           tmo;
  logic           rd_ok;

  // Outgoing shift uses the live address; return shift the latched one.
  assign align_off = (state_q == IDLE) ? mem_address[1:0] : off_q;

  mem_lane_align u_align (
    .off      (align_off),
    .wdata    (mem_wdata),
    .mask     (mem_byte_enable),
    .rdata    (pmem_rdata),
    .wdata_sh (wdata_sh),
    .mask_sh  (mask_sh),
    .ovf      (ovf),
    .rdata_sh (rdata_sh)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    err_d   = 1'b0;
    tmo     = 1'b0;
    rd_ok   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read && mem_write) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else if (mem_read || mem_write) begin
          if (ovf) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
            accept  = 1'b1;
          end
        end
      end
      REQ: begin
        if (pmem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (pmem_rvalid) begin
          state_d = RESP;
          rd_ok   = ~we_q;
        end else if (cnt_q == TMO) begin
          state_d = RESP;
          err_d   = 1'b1;
          tmo     = 1'b1;
        end
      end
      RESP: begin
        state_d = pend_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (pmem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      off_q      <= 2'b00;
      we_q       <= 1'b0;
      pend_q     <= 1'b0;
      cnt_q      <= 8'd0;
      mem_err    <= 1'b0;
      mem_rdata  <= 32'd0;
      pmem_addr  <= 32'd0;
      pmem_wdata <= 32'd0;
      pmem_wmask <= 4'b0000;
    end else begin
      state_q <= state_d;
      mem_err <= err_d;
      if (accept) begin
        off_q      <= mem_address[1:0];
        we_q       <= mem_write;
        pmem_addr  <= {mem_address[31:2], 2'b00};
        pmem_wdata <= wdata_sh;
        pmem_wmask <= mask_sh;
      end
      if (state_q == REQ && pmem_gnt) begin
        cnt_q <= 8'd0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (tmo) begin
        pend_q <= 1'b1;
      end else if (state_q == DRAIN && pmem_rvalid) begin
        pend_q <= 1'b0;
      end
      if (state_q != RESP && state_d == RESP) begin
        mem_rdata <= rd_ok ? rdata_sh : 32'd0;
      end
    end
  end

  assign mem_resp = (state_q == RESP);
  assign pmem_req = (state_q == REQ);
  assign pmem_we  = pmem_req & we_q;

endmodule
